// File: rtl/alu_in_txn_capture_if.sv
// Monitored ALU input bus: request handshake plus opcode/operands and the
// ALU's own active-low reset. The capture block only ever listens (slave).
interface alu_in_txn_capture_if #(
  parameter int unsigned OP_WIDTH = 8
);
  logic                alu_rst;
  logic                valid;
  logic                ready;
  logic [2:0]          op;
  logic [OP_WIDTH-1:0] a;
  logic [OP_WIDTH-1:0] b;

  modport master (output alu_rst, valid, ready, op, a, b);
  modport slave  (input  alu_rst, valid, ready, op, a, b);
endinterface

// File: rtl/alu_in_txn_capture.sv
// Passive ALU input monitor: timestamps and buffers every accepted operation
// in a small FIFO for a downstream consumer, counts ops lost to a full FIFO,
// and flags sticky protocol violations seen while a request is stalled.
module alu_in_txn_capture #(
  parameter int unsigned OP_WIDTH  = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_in_txn_capture_if.slave      alu_in,
  input  logic                     enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [OP_WIDTH-1:0]      out_a,
  output logic [OP_WIDTH-1:0]      out_b,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  output logic [1:0]               proto_err,
  input  logic                     err_clr
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [2:0]          op;
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    req_t                req;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  typedef enum logic {IDLE, STALL} trk_state_e;

  entry_t                 mem_q [DEPTH];
  entry_t                 mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [1:0]             proto_err_q, proto_err_d;
  trk_state_e             state_q, state_d;
  req_t                   lat_q, lat_d;

  req_t   cur;
  logic   accept, capture, pop, full, push, drop;
  logic [1:0] err_set;

  assign cur     = '{op: alu_in.op, a: alu_in.a, b: alu_in.b};
  assign accept  = alu_in.alu_rst & alu_in.valid & alu_in.ready;
  assign capture = accept & enable;
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = out_valid & out_ready;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign out_valid = (level_q != '0);
  assign out_op    = mem_q[rd_ptr_q].req.op;
  assign out_a     = mem_q[rd_ptr_q].req.a;
  assign out_b     = mem_q[rd_ptr_q].req.b;
  assign out_ts    = mem_q[rd_ptr_q].ts;
  assign level     = level_q;
  assign drop_cnt  = drop_cnt_q;
  assign proto_err = proto_err_q;

  // FIFO storage, pointers, occupancy and free-running timestamp
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ts_d     = ts_q + TS_WIDTH'(1);
    if (push) begin
      mem_d[wr_ptr_q] = '{req: cur, ts: ts_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Protocol tracker: watches a stalled request for withdrawal or payload change
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    err_set = '0;
    if (!alu_in.alu_rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (alu_in.valid && !alu_in.ready) begin
            state_d = STALL;
            lat_d   = cur;
          end
        end
        STALL: begin
          if (alu_in.valid && alu_in.ready) begin
            state_d = IDLE;
          end else if (!alu_in.valid) begin
            state_d    = IDLE;
            err_set[0] = 1'b1;
          end else begin
            if (cur != lat_q) err_set[1] = 1'b1;
            lat_d = cur;
          end
        end
      endcase
    end
  end

  // Sticky error / drop counters: clear first, so an event in the clear cycle survives
  always_comb begin
    proto_err_d = (err_clr ? 2'b00 : proto_err_q) | err_set;
    drop_cnt_d  = err_clr ? '0 : drop_cnt_q;
    if (drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + CNT_WIDTH'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ts_q        <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= '0;
      state_q     <= IDLE;
      lat_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ts_q        <= ts_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
    end
  end
endmodule
